// File: rtl/dot4_acc_pkg.sv
// Shared state codes and default sizing for the dot4_acc streaming dot-product unit.
package dot4_acc_pkg;

    typedef enum logic {
        DOT_ACCUM = 1'b0,
        DOT_HOLD  = 1'b1
    } dot_state_e;

    localparam int DOT_N_TERMS_DEF = 4;
    localparam int DOT_ACC_W_DEF   = 12;

endpackage

// File: rtl/dot4_acc_if.sv
// Operand-in / result-out handshake bundle of dot4_acc; master is the producer/consumer side.
interface dot4_acc_if
    import dot4_acc_pkg::*;
#(
    parameter int ACC_W = DOT_ACC_W_DEF
) ();

    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic             ovf;

    modport master (
        output clr, in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  clr, in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, ovf
    );

endinterface

// File: rtl/mul4.sv
// Unsigned 4x4 multiplier, purely combinational: s = a * b.
module mul4 (
    output logic [7:0] s,
    input  logic [3:0] a,
    input  logic [3:0] b
);

    always_comb begin
        s = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                s = s + (8'(a) << i);
            end
        end
    end

endmodule

// File: rtl/dot4_acc.sv
// Accumulates N_TERMS products a*b and presents the sum; result valid 1 cycle after the last accept.
// Backpressure: while a result waits for out_ready, in_ready is low and no operand pair is taken.
module dot4_acc
    import dot4_acc_pkg::*;
#(
    parameter int N_TERMS = DOT_N_TERMS_DEF,
    parameter int ACC_W   = DOT_ACC_W_DEF
) (
    input  logic       ck,
    input  logic       rst_n,
    dot4_acc_if.slave  bus
);

    localparam int              CNT_W = $clog2(N_TERMS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    dot_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic [7:0]       prod;
    logic [ACC_W:0]   add_full;
    logic             carry;

    mul4 u_mul4 (
        .s (prod),
        .a (bus.a),
        .b (bus.b)
    );

    // One extra bit on the adder exposes the carry out of ACC_W.
    assign add_full = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod};
    assign carry    = add_full[ACC_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;

        if (state_q == DOT_ACCUM) begin
            if (bus.clr) begin
                cnt_d     = '0;
                acc_d     = '0;
                ovf_acc_d = 1'b0;
            end else if (bus.in_valid) begin
                if (cnt_q == LAST) begin
                    sum_d     = add_full[ACC_W-1:0];
                    ovf_d     = ovf_acc_q | carry;
                    state_d   = DOT_HOLD;
                end else begin
                    acc_d     = add_full[ACC_W-1:0];
                    cnt_d     = cnt_q + 1'b1;
                    ovf_acc_d = ovf_acc_q | carry;
                end
            end
        end else begin
            // clr has no effect here; only the result handshake leaves HOLD.
            if (bus.out_ready) begin
                state_d   = DOT_ACCUM;
                cnt_d     = '0;
                acc_d     = '0;
                ovf_acc_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q   <= DOT_ACCUM;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == DOT_ACCUM);
    assign bus.out_valid = (state_q == DOT_HOLD);
    assign bus.sum       = sum_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_dot4_acc.sv
// Bench for dot4_acc: three instances (4 terms/12 bits, 4 terms/8 bits, 1 term/12 bits).
module tb_dot4_acc;

    localparam int NA = 4;
    localparam int WA = 12;
    localparam int WB = 8;

    logic ck = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference state for dut_a: pending result flag, running true total and term count
    bit mh = 1'b0;
    int mt = 0;
    int mn = 0;
    int es = 0;
    bit eo = 1'b0;

    always #10 ck = ~ck;

    dot4_acc_if #(.ACC_W(WA)) ia ();
    dot4_acc_if #(.ACC_W(WB)) ib ();
    dot4_acc_if #(.ACC_W(12)) ic ();

    dot4_acc #(.N_TERMS(NA), .ACC_W(WA)) dut_a (.ck(ck), .rst_n(rst_a), .bus(ia.slave));
    dot4_acc #(.N_TERMS(4),  .ACC_W(WB)) dut_b (.ck(ck), .rst_n(rst_b), .bus(ib.slave));
    dot4_acc #(.N_TERMS(1),  .ACC_W(12)) dut_c (.ck(ck), .rst_n(rst_c), .bus(ic.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc_a(input logic rn, input logic v, input logic [3:0] aa, input logic [3:0] bb,
                         input logic cl, input logic ordy);
        rst_a        = rn;
        ia.in_valid  = v;
        ia.a         = aa;
        ia.b         = bb;
        ia.clr       = cl;
        ia.out_ready = ordy;
        @(posedge ck);
        if (!rn) begin
            mh = 1'b0; mt = 0; mn = 0; es = 0; eo = 1'b0;
        end else if (mh) begin
            if (ordy) begin
                mh = 1'b0; mt = 0; mn = 0;
            end
        end else if (cl) begin
            mt = 0; mn = 0;
        end else if (v) begin
            mt = mt + int'(aa) * int'(bb);
            mn = mn + 1;
            if (mn == NA) begin
                es = mt % (1 << WA);
                eo = (mt >= (1 << WA));
                mh = 1'b1;
            end
        end
        #1;
        chk("a_in_ready",  ia.in_ready,  !mh);
        chk("a_out_valid", ia.out_valid, mh);
        chk("a_sum",       ia.sum,       es);
        chk("a_ovf",       ia.ovf,       eo);
    endtask

    task automatic cyc_b(input logic rn, input logic v, input logic [3:0] aa, input logic [3:0] bb,
                         input logic ordy);
        rst_b        = rn;
        ib.in_valid  = v;
        ib.a         = aa;
        ib.b         = bb;
        ib.out_ready = ordy;
        @(posedge ck);
        #1;
    endtask

    task automatic cyc_c(input logic rn, input logic v, input logic [3:0] aa, input logic [3:0] bb,
                         input logic ordy);
        rst_c        = rn;
        ic.in_valid  = v;
        ic.a         = aa;
        ic.b         = bb;
        ic.out_ready = ordy;
        @(posedge ck);
        #1;
    endtask

    initial begin
        int e0;
        bit bad;
        logic [3:0] ra, rb;

        ia.clr = 1'b0; ia.in_valid = 1'b0; ia.a = '0; ia.b = '0; ia.out_ready = 1'b0;
        ib.clr = 1'b0; ib.in_valid = 1'b0; ib.a = '0; ib.b = '0; ib.out_ready = 1'b0;
        ic.clr = 1'b0; ic.in_valid = 1'b0; ic.a = '0; ic.b = '0; ic.out_ready = 1'b0;

        // reset state
        cyc_a(0, 0, 0, 0, 0, 0);
        cyc_a(0, 1, 3, 3, 0, 1);
        chk("rst_sum", ia.sum, 0);
        chk("rst_in_ready", ia.in_ready, 1);
        cyc_a(1, 0, 0, 0, 0, 0);

        // 1: plain sum, back-to-back
        cyc_a(1, 1, 3, 5, 0, 0);
        cyc_a(1, 1, 2, 7, 0, 0);
        cyc_a(1, 1, 15, 15, 0, 0);
        chk("t1_not_yet", ia.out_valid, 0);
        cyc_a(1, 1, 0, 9, 0, 0);
        chk("t1_valid", ia.out_valid, 1);
        chk("t1_sum", ia.sum, 254);
        chk("t1_ovf", ia.ovf, 0);

        // 3: backpressure with in_valid held high
        for (int i = 0; i < 5; i++) begin
            ra = 4'($urandom); rb = 4'($urandom);
            cyc_a(1, 1, ra, rb, 0, 0);
            chk("t3_stable_sum", ia.sum, 254);
            chk("t3_in_ready", ia.in_ready, 0);
        end
        cyc_a(1, 1, 9, 9, 0, 1);
        cyc_a(1, 1, 4, 4, 0, 0);
        cyc_a(1, 1, 1, 2, 0, 0);
        cyc_a(1, 1, 3, 3, 0, 0);
        cyc_a(1, 1, 0, 7, 0, 0);
        chk("t3_next_sum", ia.sum, 27);
        cyc_a(1, 0, 0, 0, 0, 1);

        // 4: clr with a simultaneous pair
        cyc_a(1, 1, 9, 9, 0, 0);
        cyc_a(1, 1, 9, 9, 0, 0);
        cyc_a(1, 1, 7, 7, 1, 0);
        chk("t4_ready_under_clr", ia.in_ready, 1);
        for (int i = 0; i < 4; i++) cyc_a(1, 1, 1, 1, 0, 0);
        chk("t4_sum", ia.sum, 4);
        cyc_a(1, 1, 6, 6, 1, 1);

        // 5: reset in HOLD, then reset with two terms accumulated
        for (int i = 0; i < 4; i++) cyc_a(1, 1, 5, 5, 0, 0);
        chk("t5_hold", ia.out_valid, 1);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("t5_rst_valid", ia.out_valid, 0);
        chk("t5_rst_sum", ia.sum, 0);
        cyc_a(1, 1, 2, 2, 0, 0);
        cyc_a(1, 1, 2, 2, 0, 0);
        cyc_a(0, 1, 2, 2, 0, 0);
        for (int i = 0; i < 4; i++) cyc_a(1, 1, 2, 3, 0, 0);
        chk("t5_post_rst_sum", ia.sum, 24);
        cyc_a(1, 0, 0, 0, 0, 1);

        // randomized traffic against the reference
        for (int i = 0; i < 150; i++) begin
            ra = 4'($urandom); rb = 4'($urandom);
            cyc_a(1, ($urandom % 4) != 0, ra, rb, ($urandom % 16) == 0, $urandom % 2);
        end

        // 2: overflow with 8-bit accumulator
        cyc_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc_b(1, 1, 15, 15, 0);
        chk("t2_valid", ib.out_valid, 1);
        chk("t2_sum", ib.sum, 132);
        chk("t2_ovf", ib.ovf, 1);
        cyc_b(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc_b(1, 1, 1, 2, 0);
        chk("t2b_sum", ib.sum, 8);
        chk("t2b_ovf", ib.ovf, 0);

        // 6: exhaustive single-term sweep
        cyc_c(0, 0, 0, 0, 0);
        bad = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (!bad) begin
                e0 = errors;
                cyc_c(1, 1, 4'(i), 4'(i >> 4), 1);
                chk("t6_valid", ic.out_valid, 1);
                chk("t6_sum", ic.sum, (i % 16) * (i / 16));
                chk("t6_ovf", ic.ovf, 0);
                cyc_c(1, 1, 4'(i), 4'(i >> 4), 1);
                chk("t6_no_passthru", ic.out_valid, 0);
                if (errors != e0) bad = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
